// File: rtl/regfile_tagged_pkg.sv
// Shared register-file constants: default geometry, tag width and the zero word.
package regfile_tagged_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREG  = 32;
    localparam int DEF_TAG_W = 4;
    localparam int DEF_NRD   = 2;

    localparam logic [DEF_XLEN-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile_tagged_rdport.sv
// One combinational read port: x0 masking, commit-data bypass and post-commit busy.
// Latency 0; no backpressure.
module regfile_tagged_rdport
    import regfile_tagged_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREG  = DEF_NREG,
    parameter int AW    = $clog2(NREG),
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             rst,
    input  logic [AW-1:0]    addr,
    input  logic [XLEN-1:0]  vals [NREG],
    input  logic [NREG-1:0]  busy_vec,
    input  logic [TAG_W-1:0] tags [NREG],
    input  logic             cm_we,
    input  logic [AW-1:0]    cm_addr,
    input  logic [TAG_W-1:0] cm_tag,
    input  logic [XLEN-1:0]  cm_data,
    output logic [XLEN-1:0]  data,
    output logic             busy,
    output logic [TAG_W-1:0] tag
);

    always_comb begin
        data = XLEN'(ZeroWord);
        busy = 1'b0;
        tag  = '0;
        if (!rst && addr != '0) begin
            data = vals[addr];
            busy = busy_vec[addr];
            tag  = tags[addr];
            // A matching commit in this cycle retires the producer the reader sees.
            if (cm_we && cm_addr == addr) begin
                data = cm_data;
                if (tags[addr] == cm_tag) begin
                    busy = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_tagged.sv
// Architectural register file with per-register busy bit and ROB rename tag.
// Reads are combinational; rename/commit/flush land on the next clk; no backpressure.
module regfile_tagged
    import regfile_tagged_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREG  = DEF_NREG,
    parameter int AW    = $clog2(NREG),
    parameter int TAG_W = DEF_TAG_W,
    parameter int NRD   = DEF_NRD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    output logic [NRD*TAG_W-1:0]  rd_tag,
    input  logic                  ren_we,
    input  logic [AW-1:0]         ren_addr,
    input  logic [TAG_W-1:0]      ren_tag,
    input  logic                  cm_we,
    input  logic [AW-1:0]         cm_addr,
    input  logic [TAG_W-1:0]      cm_tag,
    input  logic [XLEN-1:0]       cm_data,
    input  logic                  flush
);

    logic [XLEN-1:0]  vals [NREG];
    logic [TAG_W-1:0] tags [NREG];
    logic [NREG-1:0]  busy_vec;

    logic cm_en;
    logic ren_en;

    assign cm_en  = cm_we && (cm_addr != '0);
    assign ren_en = ren_we && (ren_addr != '0) && !flush;

    // Later assignments take priority: rename beats a commit's busy clear, flush beats both.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                vals[i] <= XLEN'(ZeroWord);
                tags[i] <= '0;
            end
            busy_vec <= '0;
        end else begin
            if (cm_en) begin
                vals[cm_addr] <= cm_data;
                if (tags[cm_addr] == cm_tag) begin
                    busy_vec[cm_addr] <= 1'b0;
                end
            end
            if (ren_en) begin
                busy_vec[ren_addr] <= 1'b1;
                tags[ren_addr]     <= ren_tag;
            end
            if (flush) begin
                busy_vec <= '0;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rdport
        regfile_tagged_rdport #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .AW    (AW),
            .TAG_W (TAG_W)
        ) u_rdport (
            .rst      (rst),
            .addr     (rd_addr[g*AW +: AW]),
            .vals     (vals),
            .busy_vec (busy_vec),
            .tags     (tags),
            .cm_we    (cm_we),
            .cm_addr  (cm_addr),
            .cm_tag   (cm_tag),
            .cm_data  (cm_data),
            .data     (rd_data[g*XLEN +: XLEN]),
            .busy     (rd_busy[g]),
            .tag      (rd_tag[g*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_regfile_tagged.sv
// Directed cycle-by-cycle vectors for regfile_tagged with hand-computed read results.
module tb_regfile_tagged;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [7:0]  rd_tag;
    logic        ren_we;
    logic [4:0]  ren_addr;
    logic [3:0]  ren_tag;
    logic        cm_we;
    logic [4:0]  cm_addr;
    logic [3:0]  cm_tag;
    logic [31:0] cm_data;
    logic        flush;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_tagged dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .rd_tag   (rd_tag),
        .ren_we   (ren_we),
        .ren_addr (ren_addr),
        .ren_tag  (ren_tag),
        .cm_we    (cm_we),
        .cm_addr  (cm_addr),
        .cm_tag   (cm_tag),
        .cm_data  (cm_data),
        .flush    (flush)
    );

    typedef struct {
        logic        rst;
        logic        ren_we;
        logic [4:0]  ren_a;
        logic [3:0]  ren_t;
        logic        cm_we;
        logic [4:0]  cm_a;
        logic [3:0]  cm_t;
        logic [31:0] cm_d;
        logic        flush;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic        eb0;
        logic [3:0]  et0;
        logic [31:0] ed1;
        logic        eb1;
        logic [3:0]  et1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rw, logic [4:0] ra, logic [3:0] rt,
                                logic cw, logic [4:0] ca, logic [3:0] ct, logic [31:0] cd,
                                logic fl, logic [4:0] a0, logic [4:0] a1,
                                logic [31:0] d0, logic b0, logic [3:0] t0,
                                logic [31:0] d1, logic b1, logic [3:0] t1);
        vec_t v;
        v.rst = r;   v.ren_we = rw; v.ren_a = ra; v.ren_t = rt;
        v.cm_we = cw; v.cm_a = ca;  v.cm_t = ct;  v.cm_d = cd;
        v.flush = fl; v.ra0 = a0;   v.ra1 = a1;
        v.ed0 = d0;  v.eb0 = b0;    v.et0 = t0;
        v.ed1 = d1;  v.eb1 = b1;    v.et1 = t1;
        return v;
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst      = v.rst;
        ren_we   = v.ren_we; ren_addr = v.ren_a; ren_tag = v.ren_t;
        cm_we    = v.cm_we;  cm_addr  = v.cm_a;  cm_tag  = v.cm_t; cm_data = v.cm_d;
        flush    = v.flush;
        rd_addr  = {v.ra1, v.ra0};
    endtask

    // Tag is only meaningful while busy, except x0 which must always read tag 0.
    task automatic check_port(int step, int p, logic [4:0] a, logic [31:0] d, logic b, logic [3:0] t);
        cmp($sformatf("step%0d p%0d data", step, p), rd_data[p*32 +: 32], d);
        cmp($sformatf("step%0d p%0d busy", step, p), 32'(rd_busy[p]), 32'(b));
        if (b || a == 5'd0)
            cmp($sformatf("step%0d p%0d tag", step, p), 32'(rd_tag[p*4 +: 4]), 32'(t));
    endtask

    initial begin
        //            rst rw ra  rt  cw ca  ct  cd            fl a0  a1   d0            b0 t0  d1     b1 t1
        vecs.push_back(mk(1, 0, 0,  0, 0, 0,  0, 0,            0, 5,  0,   0,            0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0,            0, 5,  0,   0,            0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 1, 3,  7, 0, 0,  0, 0,            0, 3,  0,   0,            0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0,            0, 3,  5,   0,            1, 7,  0,     0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 1, 3,  7, 32'hDEADBEEF, 0, 3,  0,   32'hDEADBEEF, 0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0,            0, 3,  3,   32'hDEADBEEF, 0, 0,  32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 1, 4,  2, 0, 0,  0, 0,            0, 4,  0,   0,            0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 1, 4,  5, 0, 0,  0, 0,            0, 4,  0,   0,            1, 2,  0,     0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 1, 4,  2, 32'h11,       0, 4,  0,   32'h11,       1, 5,  0,     0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0,            0, 4,  0,   32'h11,       1, 5,  0,     0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 1, 4,  5, 32'h22,       0, 4,  0,   32'h22,       0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0,            0, 4,  0,   32'h22,       0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 1, 6,  1, 0, 0,  0, 0,            0, 6,  0,   0,            0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 1, 6,  9, 1, 6,  1, 32'h33,       0, 6,  0,   32'h33,       0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0,            0, 6,  0,   32'h33,       1, 9,  0,     0, 0));
        vecs.push_back(mk(0, 1, 1,  3, 0, 0,  0, 0,            0, 1,  0,   0,            0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 1, 2,  4, 0, 0,  0, 0,            0, 1,  0,   0,            1, 3,  0,     0, 0));
        vecs.push_back(mk(0, 1, 7,  6, 0, 0,  0, 0,            0, 2,  6,   0,            1, 4,  32'h33, 1, 9));
        vecs.push_back(mk(0, 1, 8,  8, 1, 2,  4, 32'h44,       1, 7,  1,   0,            1, 6,  0,     1, 3));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0,            0, 8,  2,   0,            0, 0,  32'h44, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0,            0, 1,  7,   0,            0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 1, 0,  5, 1, 0,  0, 32'h55,       0, 0,  6,   0,            0, 0,  32'h33, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0,            0, 0,  2,   0,            0, 0,  32'h44, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0, 1, 5,  0, 32'h66,       0, 5,  2,   0,            0, 0,  0,     0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,  0, 0,            0, 5,  2,   0,            0, 0,  0,     0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #3;
            check_port(i, 0, vecs[i].ra0, vecs[i].ed0, vecs[i].eb0, vecs[i].et0);
            check_port(i, 1, vecs[i].ra1, vecs[i].ed1, vecs[i].eb1, vecs[i].et1);
            @(posedge clk);
            #1;
        end

        // Reset mid-stream drops a pending rename and a same-cycle commit.
        drive(mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 9, 10, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rd_addr = {5'd10, 5'd9};
        #1;
        cmp("pre_rst x9 busy", 32'(rd_busy[0]), 32'd1);
        cmp("pre_rst x9 tag", 32'(rd_tag[3:0]), 32'd1);
        drive(mk(1, 1, 10, 2, 1, 9, 1, 32'h77, 0, 9, 10, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 10, 0, 0, 0, 0, 0, 0));
        #1;
        cmp("post_rst x9 data", rd_data[31:0], 32'h0);
        cmp("post_rst x9 busy", 32'(rd_busy[0]), 32'd0);
        cmp("post_rst x10 busy", 32'(rd_busy[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
